// File: rtl/serial_pattern_gen.sv
// Serial pattern transmitter: shifts data[len-1:0] out MSB-first on PO,
// repeating the word rep+1 times with GAP idle cycles between repetitions.
//
// state | meaning
// IDLE  | waiting for load; PO/PV/busy low
// SHIFT | driving pattern bits, PV high
// GAPW  | idle gap between repetitions, busy still high
module serial_pattern_gen #(
  parameter int W   = 16,
  parameter int LW  = 5,
  parameter int GAP = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [W-1:0]  data,
  input  logic [LW-1:0] len,
  input  logic [3:0]    rep,
  input  logic          abort,
  output logic          PO,
  output logic          PV,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, GAPW} state_t;

  state_t        state;
  logic [W-1:0]  word_reg;
  logic [W-1:0]  shreg;
  logic [LW-1:0] len_reg;
  logic [LW-1:0] cnt;
  logic [3:0]    remaining;
  logic [GW-1:0] gap_cnt;
  logic          len_ok;
  logic [W-1:0]  aligned;

  assign len_ok  = (len != '0) && (len <= LW'(W));
  // Left-align the active field so the first bit always sits at the MSB.
  assign aligned = data << (LW'(W) - len);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      word_reg  <= '0;
      shreg     <= '0;
      len_reg   <= '0;
      cnt       <= '0;
      remaining <= '0;
      gap_cnt   <= '0;
      PO        <= 1'b0;
      PV        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            if (len_ok) begin
              word_reg  <= aligned;
              shreg     <= aligned << 1;
              len_reg   <= len;
              cnt       <= len - LW'(1);
              remaining <= rep;
              PO        <= aligned[W-1];
              PV        <= 1'b1;
              busy      <= 1'b1;
              state     <= SHIFT;
            end else begin
              err <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (abort) begin
            state <= IDLE;
            PO    <= 1'b0;
            PV    <= 1'b0;
            busy  <= 1'b0;
          end else if (cnt != '0) begin
            PO    <= shreg[W-1];
            shreg <= shreg << 1;
            cnt   <= cnt - LW'(1);
          end else if (remaining != '0) begin
            remaining <= remaining - 4'd1;
            if (GAP == 0) begin
              PO    <= word_reg[W-1];
              shreg <= word_reg << 1;
              cnt   <= len_reg - LW'(1);
            end else begin
              state   <= GAPW;
              gap_cnt <= GW'(GAP);
              PO      <= 1'b0;
              PV      <= 1'b0;
            end
          end else begin
            state <= IDLE;
            PO    <= 1'b0;
            PV    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        GAPW: begin
          if (abort) begin
            state <= IDLE;
            PO    <= 1'b0;
            PV    <= 1'b0;
            busy  <= 1'b0;
          end else if (gap_cnt == GW'(1)) begin
            state <= SHIFT;
            PO    <= word_reg[W-1];
            PV    <= 1'b1;
            shreg <= word_reg << 1;
            cnt   <= len_reg - LW'(1);
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Bench for serial_pattern_gen: GAP=0 and GAP=2 instances share stimulus and
// are each checked cycle by cycle against a queue-based reference model.
module tb_serial_pattern_gen;

  typedef struct packed {
    logic po;
    logic pv;
    logic busy;
    logic done;
    logic err;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] data = '0;
  logic [4:0]  len = '0;
  logic [3:0]  rep = '0;

  logic po0, pv0, busy0, done0, err0;
  logic po2, pv2, busy2, done2, err2;

  int checks = 0;
  int errors = 0;

  rec_t pend[2][$];
  rec_t exp_q[2][$];
  bit   mbusy[2];

  serial_pattern_gen #(.W(16), .LW(5), .GAP(0)) u_gap0 (
    .clk(clk), .reset(rst), .load(load), .data(data), .len(len), .rep(rep),
    .abort(abort), .PO(po0), .PV(pv0), .busy(busy0), .done(done0), .err(err0)
  );

  serial_pattern_gen #(.W(16), .LW(5), .GAP(2)) u_gap2 (
    .clk(clk), .reset(rst), .load(load), .data(data), .len(len), .rep(rep),
    .abort(abort), .PO(po2), .PV(pv2), .busy(busy2), .done(done2), .err(err2)
  );

  always #5 clk = ~clk;

  function automatic rec_t act(input int i);
    return (i == 0) ? {po0, pv0, busy0, done0, err0} : {po2, pv2, busy2, done2, err2};
  endfunction

  function automatic rec_t mk(input logic po, input logic pv, input logic bz,
                              input logic dn, input logic er);
    return {po, pv, bz, dn, er};
  endfunction

  // Whole transfer is expanded into a list of per-cycle outputs at load time.
  task automatic model(input int i, input bit ld, input bit ab, input logic [15:0] d,
                       input logic [4:0] l, input logic [3:0] r, output rec_t e);
    int gaps;
    gaps = (i == 0) ? 0 : 2;
    e = '0;
    if (!mbusy[i]) begin
      if (ld) begin
        if (l >= 5'd1 && l <= 5'd16) begin
          for (int k = 0; k <= int'(r); k++) begin
            for (int b = int'(l) - 1; b >= 0; b--) pend[i].push_back(mk(d[b], 1'b1, 1'b1, 1'b0, 1'b0));
            if (k < int'(r))
              for (int g = 0; g < gaps; g++) pend[i].push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
          end
          pend[i].push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
          e = pend[i].pop_front();
        end else begin
          e.err = 1'b1;
        end
      end
    end else if (ab) begin
      pend[i].delete();
    end else begin
      e = pend[i].pop_front();
    end
    mbusy[i] = e.busy;
  endtask

  task automatic step(input bit ld, input bit ab, input logic [15:0] d,
                      input logic [4:0] l, input logic [3:0] r);
    rec_t e;
    @(negedge clk);
    load = ld; abort = ab; data = d; len = l; rep = r;
    for (int i = 0; i < 2; i++) begin
      model(i, ld, ab, d, l, r, e);
      exp_q[i].push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 16'h0, 5'd0, 4'd0);
  endtask

  task automatic check_zero(input string name);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (act(i) !== rec_t'(0)) begin
        errors++;
        $display("FAIL %s gap%0d: got %b expected 00000", name, i * 2, act(i));
      end
    end
  endtask

  // Monitor: one expected record per clock edge, compared just after the edge.
  initial begin
    rec_t e;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (exp_q[i].size() > 0) begin
          e = exp_q[i].pop_front();
          checks++;
          if (act(i) !== e) begin
            errors++;
            $display("FAIL out gap%0d t=%0t: got {po,pv,busy,done,err}=%b expected %b",
                     i * 2, $time, act(i), e);
          end
        end
      end
    end
  end

  initial begin
    bit          r_ld, r_ab;
    logic [4:0]  r_len;
    logic [3:0]  r_rep;
    mbusy[0] = 1'b0;
    mbusy[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_state");
    @(negedge clk);
    rst = 1'b0;

    step(1'b1, 1'b0, 16'h000B, 5'd4, 4'd0);  idle(6);
    step(1'b1, 1'b0, 16'hFFFB, 5'd4, 4'd2);  idle(18);
    step(1'b1, 1'b0, 16'h1234, 5'd0, 4'd0);  idle(2);
    step(1'b1, 1'b0, 16'h1234, 5'd17, 4'd0); idle(2);
    step(1'b1, 1'b0, 16'h00A5, 5'd8, 4'd0);  idle(3);
    step(1'b1, 1'b0, 16'h00FF, 5'd8, 4'd0);  idle(4);
    step(1'b1, 1'b0, 16'h0003, 5'd2, 4'd1);  idle(8);
    step(1'b1, 1'b0, 16'hBEEF, 5'd16, 4'd0); idle(5);
    step(1'b0, 1'b1, 16'h0, 5'd0, 4'd0);     idle(20);
    step(1'b1, 1'b0, 16'h8001, 5'd16, 4'd1); idle(18);
    step(1'b0, 1'b1, 16'h0, 5'd0, 4'd0);     idle(4);
    step(1'b1, 1'b1, 16'h000D, 5'd4, 4'd0);  idle(6);

    step(1'b1, 1'b0, 16'hC3A5, 5'd16, 4'd0); idle(6);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_zero("async_reset");
    for (int i = 0; i < 2; i++) begin
      pend[i].delete();
      mbusy[i] = 1'b0;
    end
    idle(1);
    rst = 1'b0;
    idle(3);

    for (int n = 0; n < 3000; n++) begin
      r_ld  = ($urandom_range(0, 5) == 0);
      r_ab  = ($urandom_range(0, 59) == 0);
      r_len = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 16));
      r_rep = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      step(r_ld, r_ab, 16'($urandom), r_len, r_rep);
    end
    idle(320);
    @(posedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
